fpu_divide_sequencer: RTL and testbench
=======================================

// Module: fpu_divide_sequencer
// PURPOSE
//  Multi-cycle restoring mantissa divider for the single-precision FPU divide path.
//  Produces the 51-bit quotient floor((a << 27) / b): 48 integer-step bits plus 3 guard bits, ready for FPU_round.
//  Retires BITS_PER_CYCLE quotient bits per cycle, replacing the fully unrolled combinational loop.
//  Sits between FPU decode/unpack (upstream) and round/pack (downstream), with valid/ready on both sides.
// PARAMETERS
//  BITS_PER_CYCLE  1  quotient bits resolved per BUSY cycle; legal values 1 or 3 (must divide 51); elaboration error otherwise
//  ID_WIDTH        4  width of the opaque tag carried from input to output
// PORTS
//  clk           in   1         clock
//  rst           in   1         asynchronous reset, active-low
//  in_valid      in   1         operand pair valid
//  in_ready      out  1         sequencer can accept operands
//  in_a          in   24        dividend mantissa, hidden bit included
//  in_b          in   24        divisor mantissa, hidden bit included
//  in_id         in   ID_WIDTH  tag; returned unchanged on out_id
//  out_valid     out  1         result valid
//  out_ready     in   1         consumer accepts result
//  out_quotient  out  51        floor((a<<27)/b); bits [2:0] are guard bits
//  out_div_zero  out  1         in_b was zero
//  out_sticky    out  1         nonzero final remainder (see CONFIGURATION)
//  out_id        out  ID_WIDTH  tag of the operation
// BEHAVIOUR
//  Reset (rst low, asynchronous): state=IDLE; every output and internal register cleared to 0; in_ready=1 once rst is high.
//  States: IDLE -> BUSY -> DONE -> IDLE. in_ready = (state==IDLE). out_valid = (state==DONE).
//  IDLE: on in_valid&&in_ready, latch a, b and id.
//    - Set remainder=0, dividend shift register={a,27'b0}, count=51/BITS_PER_CYCLE-1.
//    - If b==0: go directly to DONE with quotient=all ones, div_zero=1, sticky=0.
//    - Otherwise go to BUSY.
//  BUSY: per cycle, BITS_PER_CYCLE restoring steps, MSB first:
//    - r' = {r, next dividend bit}.
//    - If r' >= b: r = r' - b and q bit = 1; else r = r' and q bit = 0.
//    - The quotient shifts in LSB-first position order.
//    - The remainder register is 25 bits wide; r < 2*b always holds, so it cannot overflow.
//    - At count==0, the last steps complete and state goes to DONE. Otherwise count decrements.
//  Latency from accept to out_valid:
//    - b!=0: 51/BITS_PER_CYCLE+1 cycles (52 for BPC=1, 18 for BPC=3).
//    - b==0: 1 cycle.
//  DONE: out_quotient, out_div_zero, out_sticky and out_id are held stable while out_valid && !out_ready.
//    - On out_ready, go to IDLE. The next operand is accepted no earlier than the following cycle.
//    - Throughput is one op per (latency+1) cycles.
//  in_valid is ignored outside IDLE. Operands do not need to be held after acceptance.
//  Reset asserted mid-BUSY or mid-DONE: the operation is discarded, no result is emitted, all state returns to reset values.
//  Boundary a==0: quotient=0, sticky=0, full latency (no early-out).
//  Boundary a==b: quotient=1<<27.
// CONFIGURATION
//  FPU_DIVIDE_STICKY_EN defined:
//    - out_sticky = (final remainder != 0), registered with the quotient.
//    - FPU_round consumes it ORed into guard[0].
//  FPU_DIVIDE_STICKY_EN undefined:
//    - out_sticky is tied to 0.
//    - The remainder-nonzero compare logic is not built.
// STRUCTURE
//  Shared package fpu (existing):
//    - typedef enum logic [1:0] fpu_divide_state_t {FPU_DIVIDE_IDLE, FPU_DIVIDE_BUSY, FPU_DIVIDE_DONE}
//    - localparam FPU_DIVIDE_QUOTIENT_WIDTH = 51
//    - localparam FPU_DIVIDE_DIVIDEND_SHIFT = 27
//  Sub-module fpu_divide_step:
//    - Purely combinational single restoring step.
//    - In: r[24:0], dividend bit, b[23:0]. Out: r_next[24:0], q_bit.
//    - Chained BITS_PER_CYCLE times in a generate loop.
//  Counter width: $clog2(51/BITS_PER_CYCLE).
// TESTING
//  Run all scenarios at BITS_PER_CYCLE=1 and 3, with and without FPU_DIVIDE_STICKY_EN.
//  1. a=0x800000, b=0x800000, out_ready=1
//     -> quotient=0x8000000, div_zero=0, sticky=0; out_valid exactly 52 (BPC=1) / 18 (BPC=3) cycles after accept.
//  2. a=0xFFFFFF, b=0x800000 -> quotient=0xFFFFFF0, sticky=0.
//  3. a=0x000001, b=0x000003
//     -> quotient=0x2AAAAAA; sticky=1 with macro, 0 without.
//  4. b=0, a=0x123456, id=0x5
//     -> out_valid 1 cycle after accept, quotient=all ones, div_zero=1, out_id=0x5.
//  5. out_ready held low 10 cycles in DONE
//     -> outputs stable, in_ready=0, new in_valid ignored; result retires on out_ready, in_ready=1 the next cycle.
//  6. rst low mid-BUSY, then 1000 random a/b with hidden bits set and random out_ready
//     -> no spurious out_valid after reset; every result equals floor((a<<27)/b), with id order preserved.

Source files
------------

// File: rtl/fpu.sv
`default_nettype none
// ============================================================================
//  Package     : fpu
//  Description : Shared FPU types and constants used by the divide path.
//                Defines the divide sequencer state encoding and the
//                quotient, dividend-shift, mantissa and remainder widths.
//  Revision    : 1.0 - initial release
// ============================================================================
package fpu;

  typedef enum logic [1:0] {
    FPU_DIVIDE_IDLE = 2'd0,
    FPU_DIVIDE_BUSY = 2'd1,
    FPU_DIVIDE_DONE = 2'd2
  } fpu_divide_state_t;

  localparam int FPU_DIVIDE_QUOTIENT_WIDTH = 51;
  localparam int FPU_DIVIDE_DIVIDEND_SHIFT = 27;
  localparam int FPU_DIVIDE_MANT_WIDTH     = 24;
  // One bit wider than the divisor: the shifted partial remainder stays below 2*b.
  localparam int FPU_DIVIDE_REM_WIDTH      = 25;

endpackage
`default_nettype wire

// File: rtl/fpu_divide_step.sv
`default_nettype none
// ============================================================================
//  Module      : fpu_divide_step
//  Description : One combinational restoring-division step.
//                Shifts the next dividend bit into the partial remainder and
//                subtracts the divisor when the trial value is large enough.
//  Ports       : r            in  25  partial remainder (always < b)
//                dividend_bit in  1   next dividend bit, MSB first
//                b            in  24  divisor
//                r_next       out 25  updated partial remainder
//                q_bit        out 1   resolved quotient bit
//  Revision    : 1.0 - initial release
// ============================================================================
module fpu_divide_step
  import fpu::*;
(
  input  logic [FPU_DIVIDE_REM_WIDTH-1:0]  r,
  input  logic                             dividend_bit,
  input  logic [FPU_DIVIDE_MANT_WIDTH-1:0] b,
  output logic [FPU_DIVIDE_REM_WIDTH-1:0]  r_next,
  output logic                             q_bit
);

  logic [FPU_DIVIDE_REM_WIDTH:0] w_trial;
  logic [FPU_DIVIDE_REM_WIDTH:0] w_diff;
  logic                          w_unused_msb;

  assign w_trial = {r, dividend_bit};
  assign w_diff  = w_trial - {2'b00, b};
  assign q_bit   = (w_trial >= {2'b00, b});
  // Because r < b on entry, the trial value is < 2*b and the result is < b,
  // so the top bit of either operand never carries information.
  assign r_next  = q_bit ? w_diff[FPU_DIVIDE_REM_WIDTH-1:0]
                         : w_trial[FPU_DIVIDE_REM_WIDTH-1:0];
  assign w_unused_msb = w_trial[FPU_DIVIDE_REM_WIDTH] ^ w_diff[FPU_DIVIDE_REM_WIDTH];

endmodule
`default_nettype wire

// File: rtl/fpu_divide_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : fpu_divide_sequencer
//  Description : Multi-cycle restoring mantissa divider for the FPU divide
//                path. Computes floor((a << 27) / b) as a 51-bit quotient
//                (48 integer bits + 3 guard bits), BITS_PER_CYCLE bits per
//                cycle, with valid/ready handshakes on both sides.
//  Build macro : FPU_DIVIDE_STICKY_EN - when defined, out_sticky reports a
//                nonzero final remainder; otherwise out_sticky is tied to 0.
//  Parameters  : BITS_PER_CYCLE (1 or 3), ID_WIDTH (tag width)
//  Ports       : clk          in  1        clock
//                rst          in  1        asynchronous reset, active-low
//                in_valid     in  1        operand pair valid
//                in_ready     out 1        ready to accept operands
//                in_a         in  24       dividend mantissa
//                in_b         in  24       divisor mantissa
//                in_id        in  ID_WIDTH operation tag
//                out_valid    out 1        result valid
//                out_ready    in  1        consumer accepts result
//                out_quotient out 51       floor((a<<27)/b), [2:0] guard bits
//                out_div_zero out 1        divisor was zero
//                out_sticky   out 1        nonzero final remainder
//                out_id       out ID_WIDTH tag of the operation
//  Revision    : 1.0 - initial release
// ============================================================================
module fpu_divide_sequencer
  import fpu::*;
#(
  parameter int BITS_PER_CYCLE = 1,
  parameter int ID_WIDTH       = 4
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  input  logic [FPU_DIVIDE_MANT_WIDTH-1:0]     in_a,
  input  logic [FPU_DIVIDE_MANT_WIDTH-1:0]     in_b,
  input  logic [ID_WIDTH-1:0]                  in_id,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic [FPU_DIVIDE_QUOTIENT_WIDTH-1:0] out_quotient,
  output logic                                 out_div_zero,
  output logic                                 out_sticky,
  output logic [ID_WIDTH-1:0]                  out_id
);

  localparam int QW       = FPU_DIVIDE_QUOTIENT_WIDTH;
  localparam int RW       = FPU_DIVIDE_REM_WIDTH;
  localparam int STEPS    = QW / BITS_PER_CYCLE;
  localparam int CNT_W    = $clog2(STEPS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STEPS - 1);

  if (BITS_PER_CYCLE != 1 && BITS_PER_CYCLE != 3) begin : g_bpc_illegal
    $error("fpu_divide_sequencer: BITS_PER_CYCLE must be 1 or 3");
  end

  fpu_divide_state_t r_state;
  fpu_divide_state_t w_state_next;

  logic [RW-1:0]                    r_rem;
  logic [QW-1:0]                    r_dividend;
  logic [FPU_DIVIDE_MANT_WIDTH-1:0] r_b;
  logic [QW-1:0]                    r_quot;
  logic [CNT_W-1:0]                 r_count;
  logic                             r_div_zero;
  logic [ID_WIDTH-1:0]              r_id;

  logic                             w_accept;
  logic                             w_last_step;
  logic [RW-1:0]                    w_rem [BITS_PER_CYCLE+1];
  logic [BITS_PER_CYCLE-1:0]        w_qbits;

  // --------------------------------------------------------------------------
  // Control FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= FPU_DIVIDE_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_last_step  = 1'b0;
    case (r_state)
      FPU_DIVIDE_IDLE: begin
        if (in_valid) begin
          w_accept     = 1'b1;
          // A zero divisor has a fixed answer, so skip the iteration.
          w_state_next = (in_b == '0) ? FPU_DIVIDE_DONE : FPU_DIVIDE_BUSY;
        end
      end
      FPU_DIVIDE_BUSY: begin
        if (r_count == '0) begin
          w_last_step  = 1'b1;
          w_state_next = FPU_DIVIDE_DONE;
        end
      end
      FPU_DIVIDE_DONE: begin
        if (out_ready) begin
          w_state_next = FPU_DIVIDE_IDLE;
        end
      end
      default: w_state_next = FPU_DIVIDE_IDLE;
    endcase
  end

  assign in_ready  = (r_state == FPU_DIVIDE_IDLE);
  assign out_valid = (r_state == FPU_DIVIDE_DONE);

  // --------------------------------------------------------------------------
  // Restoring step chain: step k consumes dividend bit (QW-1-k) and produces
  // the k-th most significant of this cycle's quotient bits.
  // --------------------------------------------------------------------------
  assign w_rem[0] = r_rem;

  for (genvar k = 0; k < BITS_PER_CYCLE; k++) begin : g_step
    fpu_divide_step u_step (
      .r            (w_rem[k]),
      .dividend_bit (r_dividend[QW-1-k]),
      .b            (r_b),
      .r_next       (w_rem[k+1]),
      .q_bit        (w_qbits[BITS_PER_CYCLE-1-k])
    );
  end

  // --------------------------------------------------------------------------
  // Datapath registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rem      <= '0;
      r_dividend <= '0;
      r_b        <= '0;
      r_quot     <= '0;
      r_count    <= '0;
      r_div_zero <= 1'b0;
      r_id       <= '0;
    end else if (w_accept) begin
      r_rem      <= '0;
      r_dividend <= {in_a, {FPU_DIVIDE_DIVIDEND_SHIFT{1'b0}}};
      r_b        <= in_b;
      r_id       <= in_id;
      r_count    <= CNT_LAST;
      r_div_zero <= (in_b == '0);
      r_quot     <= (in_b == '0) ? {QW{1'b1}} : '0;
    end else if (r_state == FPU_DIVIDE_BUSY) begin
      r_rem      <= w_rem[BITS_PER_CYCLE];
      r_dividend <= r_dividend << BITS_PER_CYCLE;
      r_quot     <= {r_quot[QW-1-BITS_PER_CYCLE:0], w_qbits};
      if (!w_last_step) begin
        r_count <= r_count - CNT_W'(1);
      end
    end
  end

`ifdef FPU_DIVIDE_STICKY_EN
  logic r_sticky;

  // Captured on the final step so it lands together with the last quotient bits.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sticky <= 1'b0;
    end else if (w_accept) begin
      r_sticky <= 1'b0;
    end else if (w_last_step) begin
      r_sticky <= |w_rem[BITS_PER_CYCLE];
    end
  end

  assign out_sticky = r_sticky;
`else
  assign out_sticky = 1'b0;
`endif

  assign out_quotient = r_quot;
  assign out_div_zero = r_div_zero;
  assign out_id       = r_id;

endmodule
`default_nettype wire

// File: tb/tb_fpu_divide_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fpu_divide_sequencer
//  Description : Self-checking bench for fpu_divide_sequencer. Runs one
//                instance at BITS_PER_CYCLE=1 and one at 3, each with its own
//                stimulus, an arithmetic reference model and a per-cycle
//                compare process. Honours FPU_DIVIDE_STICKY_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fpu_divide_sequencer;

  localparam int ID_W = 4;
`ifdef FPU_DIVIDE_STICKY_EN
  localparam bit STICKY = 1'b1;
`else
  localparam bit STICKY = 1'b0;
`endif

  typedef struct packed {
    logic [ID_W-1:0] id;
    logic [50:0]     quot;
    logic            dz;
    logic            sticky;
    int              lat;
    int              acc;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;
  bit done_flag [2];

  task automatic check(input int bpc, input string name,
                       input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL bpc%0d %s: actual 0x%0h required 0x%0h (t=%0t)",
               bpc, name, act, exp, $time);
    end
  endtask

  // Reference: plain integer division of the scaled dividend.
  function automatic exp_t model(input logic [23:0] a, input logic [23:0] b,
                                 input logic [ID_W-1:0] id, input int bpc);
    exp_t        e;
    logic [50:0] num;
    logic [50:0] den;
    num   = {a, 27'd0};
    den   = {27'd0, b};
    e.id  = id;
    e.acc = 0;
    if (b == 24'd0) begin
      e.quot   = {51{1'b1}};
      e.dz     = 1'b1;
      e.sticky = 1'b0;
      e.lat    = 1;
    end else begin
      e.quot   = num / den;
      e.dz     = 1'b0;
      e.sticky = STICKY && ((num % den) != 51'd0);
      e.lat    = 51 / bpc + 1;
    end
    return e;
  endfunction

  for (genvar gi = 0; gi < 2; gi++) begin : g_inst
    localparam int BPC     = (gi == 0) ? 1 : 3;
    localparam int LAT_LIT = (gi == 0) ? 52 : 18;

    logic            rst;
    logic            in_valid;
    logic            in_ready;
    logic [23:0]     in_a;
    logic [23:0]     in_b;
    logic [ID_W-1:0] in_id;
    logic            out_valid;
    logic            out_ready;
    logic [50:0]     out_quotient;
    logic            out_div_zero;
    logic            out_sticky;
    logic [ID_W-1:0] out_id;

    exp_t q[$];
    bit   front_seen = 1'b0;
    bit   ready_rand = 1'b0;
    bit   ready_force = 1'b1;

    fpu_divide_sequencer #(
      .BITS_PER_CYCLE (BPC),
      .ID_WIDTH       (ID_W)
    ) u_dut (
      .clk          (clk),
      .rst          (rst),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_a         (in_a),
      .in_b         (in_b),
      .in_id        (in_id),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_quotient (out_quotient),
      .out_div_zero (out_div_zero),
      .out_sticky   (out_sticky),
      .out_id       (out_id)
    );

    // Consumer: out_ready changes just after each rising edge.
    initial begin
      out_ready = 1'b0;
      forever begin
        @(posedge clk);
        #1;
        out_ready = ready_rand ? 1'($urandom_range(0, 1)) : ready_force;
      end
    end

    // Compare process: every falling edge, outputs against the model queue.
    always @(negedge clk) begin
      if (!rst) begin
        check(BPC, "reset_out_valid", out_valid, 0);
        check(BPC, "reset_quotient", out_quotient, 0);
        check(BPC, "reset_div_zero", out_div_zero, 0);
        check(BPC, "reset_sticky", out_sticky, 0);
        check(BPC, "reset_id", out_id, 0);
      end else begin
        check(BPC, "in_ready", in_ready, q.size() == 0);
        if (q.size() == 0) begin
          check(BPC, "spurious_out_valid", out_valid, 0);
        end else if (out_valid) begin
          if (!front_seen) begin
            check(BPC, "latency", cyc - q[0].acc, q[0].lat);
            front_seen = 1'b1;
          end
          check(BPC, "quotient", out_quotient, q[0].quot);
          check(BPC, "div_zero", out_div_zero, q[0].dz);
          check(BPC, "sticky", out_sticky, q[0].sticky);
          check(BPC, "id", out_id, q[0].id);
          if (out_ready) begin
            void'(q.pop_front());
            front_seen = 1'b0;
          end
        end
      end
    end

    task automatic do_op(input logic [23:0] a, input logic [23:0] b,
                         input logic [ID_W-1:0] id, output int acc);
      int   k;
      exp_t e;
      @(negedge clk);
      #2;
      in_valid = 1'b1;
      in_a     = a;
      in_b     = b;
      in_id    = id;
      k = 0;
      while (!in_ready && k < 300) begin
        @(negedge clk);
        #2;
        k++;
      end
      acc = cyc;
      if (!in_ready) begin
        check(BPC, "accept_timeout", 0, 1);
      end else begin
        e     = model(a, b, id, BPC);
        e.acc = cyc;
        q.push_back(e);
      end
      @(posedge clk);
      #1;
      // Scramble operands: the DUT must not rely on them after acceptance.
      in_valid = 1'b0;
      in_a     = 24'($urandom);
      in_b     = 24'($urandom);
      in_id    = ID_W'($urandom);
    endtask

    task automatic wait_valid(output bit ok);
      int k;
      ok = 1'b0;
      k  = 0;
      while (k < 200) begin
        @(negedge clk);
        #3;
        if (out_valid) begin
          ok = 1'b1;
          break;
        end
        k++;
      end
      if (!ok) check(BPC, "wait_valid_timeout", 0, 1);
    endtask

    task automatic directed(input logic [23:0] a, input logic [23:0] b,
                            input logic [ID_W-1:0] id, input logic [50:0] eq,
                            input logic edz, input logic est, input int elat);
      int acc;
      bit ok;
      do_op(a, b, id, acc);
      wait_valid(ok);
      if (ok) begin
        check(BPC, "dir_latency", cyc - acc, elat);
        check(BPC, "dir_quotient", out_quotient, eq);
        check(BPC, "dir_div_zero", out_div_zero, edz);
        check(BPC, "dir_sticky", out_sticky, est);
        check(BPC, "dir_id", out_id, id);
      end
      @(negedge clk);
    endtask

    initial begin
      int          acc;
      int          k;
      bit          ok;
      logic [23:0] ra;
      logic [23:0] rb;
      rst      = 1'b1;
      in_valid = 1'b0;
      in_a     = '0;
      in_b     = '0;
      in_id    = '0;
      #1 rst = 1'b0;
      repeat (3) @(negedge clk);
      #2 rst = 1'b1;

      directed(24'h800000, 24'h800000, 4'h1, 51'h8000000, 1'b0, 1'b0, LAT_LIT);
      directed(24'hFFFFFF, 24'h800000, 4'h2, 51'hFFFFFF0, 1'b0, 1'b0, LAT_LIT);
      directed(24'h000001, 24'h000003, 4'h3, 51'h2AAAAAA, 1'b0, STICKY, LAT_LIT);
      directed(24'h123456, 24'h000000, 4'h5, {51{1'b1}}, 1'b1, 1'b0, 1);
      directed(24'h000000, 24'h900000, 4'h6, 51'h0, 1'b0, 1'b0, LAT_LIT);
      directed(24'hABCDEF, 24'hABCDEF, 4'h4, 51'h8000000, 1'b0, 1'b0, LAT_LIT);

      // Back-pressure: hold out_ready low for 10 cycles in DONE.
      ready_force = 1'b0;
      do_op(24'hC00000, 24'h800000, 4'h7, acc);
      wait_valid(ok);
      for (int i = 0; i < 10; i++) begin
        in_valid = 1'b1;
        in_a     = 24'h400000;
        in_b     = 24'h800000;
        in_id    = 4'h9;
        check(BPC, "stall_in_ready", in_ready, 0);
        check(BPC, "stall_out_valid", out_valid, 1);
        check(BPC, "stall_quotient", out_quotient, 51'hC000000);
        check(BPC, "stall_id", out_id, 4'h7);
        @(negedge clk);
        #3;
      end
      in_valid    = 1'b0;
      ready_force = 1'b1;
      k = 0;
      while (out_valid && k < 10) begin
        @(negedge clk);
        #3;
        k++;
      end
      check(BPC, "retire_out_valid", out_valid, 0);
      check(BPC, "retire_in_ready", in_ready, 1);

      // Reset in the middle of an operation.
      do_op({1'b1, 23'($urandom)}, {1'b1, 23'($urandom)}, 4'hA, acc);
      repeat (10) @(negedge clk);
      #2;
      rst = 1'b0;
      q.delete();
      front_seen = 1'b0;
      repeat (3) @(negedge clk);
      #2 rst = 1'b1;

      // Random operands with hidden bits set and a random consumer.
      ready_rand = 1'b1;
      for (int i = 0; i < 1000; i++) begin
        ra = {1'b1, 23'($urandom)};
        rb = {1'b1, 23'($urandom)};
        do_op(ra, rb, ID_W'(i), acc);
      end
      k = 0;
      while (q.size() != 0 && k < 500) begin
        @(negedge clk);
        k++;
      end
      check(BPC, "drain_empty", q.size(), 0);
      done_flag[gi] = 1'b1;
    end
  end

  initial begin
    int k;
    k = 0;
    while (!(done_flag[0] && done_flag[1]) && k < 95000) begin
      @(posedge clk);
      k++;
    end
    if (!(done_flag[0] && done_flag[1])) begin
      n_checks++;
      n_fail++;
      $display("FAIL global_timeout: actual done=%0d%0d required 11",
               done_flag[1], done_flag[0]);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
